// File: rtl/dark_pkg.sv
// Shared types and helpers for the dark-mode output mixer.
//   mode_e   : requested inversion mode (auto / never / always / reverse auto)
//   state_e  : cross-fade FSM states
//   mode_inv : inversion decision of a mode for one pixel's block decision
package dark_pkg;

  typedef enum logic [1:0] {
    AUTO     = 2'b00,
    NEVER    = 2'b01,
    ALWAYS   = 2'b10,
    REV_AUTO = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_e;

  // Inversion bit a mode asks for, given the pixel's block decision.
  function automatic logic mode_inv(input mode_e mode, input logic blk_x);
    logic inv;
    inv = 1'b0;
    case (mode)
      AUTO:     inv = blk_x;
      NEVER:    inv = 1'b0;
      ALWAYS:   inv = 1'b1;
      REV_AUTO: inv = ~blk_x;
      default:  inv = 1'b0;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/mix_channel.sv
// One channel blend between a value and its complement.
//   x   : source channel value
//   w   : complement weight, 0..2^FADE_LOG2
//   y_c : floor((x*(M-w) + ~x*w) / M), combinational
module mix_channel #(
  parameter int unsigned BW        = 8,
  parameter int unsigned FADE_LOG2 = 4
) (
  input  logic [BW-1:0]      x,
  input  logic [FADE_LOG2:0] w,
  output logic [BW-1:0]      y_c
);

  localparam int unsigned LW = FADE_LOG2 + 1;
  localparam int unsigned PW = BW + FADE_LOG2 + 1;
  localparam logic [LW-1:0] LVL_M = LW'(1 << FADE_LOG2);

  logic [BW-1:0] x_n;
  logic [LW-1:0] w_keep;
  logic [PW-1:0] keep_p;
  logic [PW-1:0] flip_p;
  logic [PW-1:0] sum_p;
  logic [PW-1:0] shr_p;

  // Complement taken at BW bits before widening so the upper bits stay zero.
  always_comb begin
    x_n    = ~x;
    w_keep = LVL_M - w;
    keep_p = PW'(x) * PW'(w_keep);
    flip_p = PW'(x_n) * PW'(w);
    sum_p  = keep_p + flip_p;
    shr_p  = sum_p >> FADE_LOG2;
    y_c    = shr_p[BW-1:0];
  end

endmodule

// File: rtl/dark_mixer.sv
// Frame-synchronous dark-mode output mixer with cross-faded mode changes.
//   clk_i, rst_i           : pixel clock, async active-high reset
//   vs_i, hs_i, de_i       : input syncs / data enable
//   data_i, alt_data_i     : primary and loopback pixels (channel 0 in LSBs)
//   src_sel_i              : 1 = data_i, 0 = alt_data_i
//   blk_x_i                : block decision for the current pixel
//   mode_i                 : requested mode, sampled at frame boundaries
//   vs_o, hs_o, de_o       : syncs delayed 2 cycles
//   data_o                 : mixed pixel, zero while de_o is low
//   inv_o                  : new-mode inversion decision for data_o
//   busy_o                 : cross-fade in progress
module dark_mixer
  import dark_pkg::*;
#(
  parameter int unsigned CH        = 3,
  parameter int unsigned BW        = 8,
  parameter int unsigned FADE_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                vs_i,
  input  logic                hs_i,
  input  logic                de_i,
  input  logic [CH*BW-1:0]    data_i,
  input  logic [CH*BW-1:0]    alt_data_i,
  input  logic                src_sel_i,
  input  logic                blk_x_i,
  input  logic [1:0]          mode_i,
  output logic                vs_o,
  output logic                hs_o,
  output logic                de_o,
  output logic [CH*BW-1:0]    data_o,
  output logic                inv_o,
  output logic                busy_o
);

  localparam int unsigned DW = CH * BW;
  localparam int unsigned LW = FADE_LOG2 + 1;
  localparam logic [LW-1:0] LVL_M = LW'(1 << FADE_LOG2);

  logic          vs_q;
  state_e        state_q, state_d;
  mode_e         mode_old_q, mode_old_d;
  mode_e         mode_new_q, mode_new_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] lvl_inc;
  logic          boundary_c;

  logic          old_inv_c, new_inv_c;
  logic [LW-1:0] w_c;

  logic [DW-1:0] src_s1;
  logic [LW-1:0] w_s1;
  logic          inv_s1, vs_s1, hs_s1, de_s1;
  logic [DW-1:0] mix_c;

  // Fade controller state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q       <= 1'b0;
      state_q    <= ST_IDLE;
      mode_old_q <= AUTO;
      mode_new_q <= AUTO;
      lvl_q      <= LVL_M;
      busy_o     <= 1'b0;
    end else begin
      vs_q       <= vs_i;
      state_q    <= state_d;
      mode_old_q <= mode_old_d;
      mode_new_q <= mode_new_d;
      lvl_q      <= lvl_d;
      busy_o     <= (state_d == ST_FADE);
    end
  end

  // Next-state: start a fade on a new request, step the level once per frame.
  always_comb begin
    state_d    = state_q;
    mode_old_d = mode_old_q;
    mode_new_d = mode_new_q;
    lvl_d      = lvl_q;
    boundary_c = vs_i & ~vs_q;
    lvl_inc    = lvl_q + LW'(1);
    case (state_q)
      ST_IDLE: begin
        if (boundary_c && (mode_e'(mode_i) != mode_new_q)) begin
          mode_old_d = mode_new_q;
          mode_new_d = mode_e'(mode_i);
          lvl_d      = '0;
          state_d    = ST_FADE;
        end
      end
      ST_FADE: begin
        if (boundary_c) begin
          lvl_d = lvl_inc;
          if (lvl_inc == LVL_M) begin
            state_d    = ST_IDLE;
            mode_old_d = mode_new_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Complement weight from how the old and new modes treat this pixel.
  always_comb begin
    old_inv_c = mode_inv(mode_old_q, blk_x_i);
    new_inv_c = mode_inv(mode_new_q, blk_x_i);
    case ({old_inv_c, new_inv_c})
      2'b00:   w_c = '0;
      2'b11:   w_c = LVL_M;
      2'b01:   w_c = lvl_q;
      default: w_c = LVL_M - lvl_q;
    endcase
  end

  // Stage 1: source select, weight, syncs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_s1 <= '0;
      w_s1   <= '0;
      inv_s1 <= 1'b0;
      vs_s1  <= 1'b0;
      hs_s1  <= 1'b0;
      de_s1  <= 1'b0;
    end else begin
      src_s1 <= src_sel_i ? data_i : alt_data_i;
      w_s1   <= w_c;
      inv_s1 <= new_inv_c;
      vs_s1  <= vs_i;
      hs_s1  <= hs_i;
      de_s1  <= de_i;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    mix_channel #(
      .BW        (BW),
      .FADE_LOG2 (FADE_LOG2)
    ) u_mix (
      .x   (src_s1[c*BW +: BW]),
      .w   (w_s1),
      .y_c (mix_c[c*BW +: BW])
    );
  end

  // Stage 2: blended pixel, blanked outside the active area.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o <= '0;
      inv_o  <= 1'b0;
      vs_o   <= 1'b0;
      hs_o   <= 1'b0;
      de_o   <= 1'b0;
    end else begin
      data_o <= de_s1 ? mix_c : '0;
      inv_o  <= inv_s1;
      vs_o   <= vs_s1;
      hs_o   <= hs_s1;
      de_o   <= de_s1;
    end
  end

endmodule

// File: tb/tb_dark_mixer.sv
// Directed bench for dark_mixer: u0 with a 4-frame fade, u1 with instant switch.
module tb_dark_mixer;

  localparam int unsigned DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vs, hs, de, sel, blk;
  logic [DW-1:0] data, alt;
  logic [1:0]    mode;

  logic          vs_o0, hs_o0, de_o0, inv_o0, busy_o0;
  logic [DW-1:0] data_o0;
  logic          vs_o1, hs_o1, de_o1, inv_o1, busy_o1;
  logic [DW-1:0] data_o1;

  int n_checks = 0;
  int n_fails  = 0;

  dark_mixer #(.CH(3), .BW(8), .FADE_LOG2(2)) u0 (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
    .data_i(data), .alt_data_i(alt), .src_sel_i(sel), .blk_x_i(blk),
    .mode_i(mode), .vs_o(vs_o0), .hs_o(hs_o0), .de_o(de_o0),
    .data_o(data_o0), .inv_o(inv_o0), .busy_o(busy_o0)
  );

  dark_mixer #(.CH(3), .BW(8), .FADE_LOG2(0)) u1 (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
    .data_i(data), .alt_data_i(alt), .src_sel_i(sel), .blk_x_i(blk),
    .mode_i(mode), .vs_o(vs_o1), .hs_o(hs_o1), .de_o(de_o1),
    .data_o(data_o1), .inv_o(inv_o1), .busy_o(busy_o1)
  );

  task automatic check_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle vsync pulse, then enough cycles to flush the 2-stage pipe.
  task automatic frame();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst  = 1'b1;
    vs   = 1'b0;
    hs   = 1'b0;
    de   = 1'b1;
    sel  = 1'b1;
    blk  = 1'b1;
    mode = 2'b00;
    data = 24'h404040;
    alt  = 24'h202020;

    // Reset defaults
    repeat (2) tick();
    check_d("rst_data", data_o0, 24'h000000);
    check_b("rst_inv", inv_o0, 1'b0);
    check_b("rst_busy", busy_o0, 1'b0);
    check_b("rst_de", de_o0, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    check_d("auto_blk1_data", data_o0, 24'hBFBFBF);
    check_b("auto_blk1_inv", inv_o0, 1'b1);
    check_b("auto_blk1_busy", busy_o0, 1'b0);
    check_b("auto_blk1_de", de_o0, 1'b1);

    // Fade 00 -> 10 with a 01 request arriving mid-fade
    mode = 2'b10;
    blk  = 1'b0;
    repeat (2) tick();
    check_d("pre_fade_data", data_o0, 24'h404040);
    check_b("pre_fade_inv", inv_o0, 1'b0);
    frame();
    check_d("fade_l0", data_o0, 24'h404040);
    check_b("fade_l0_busy", busy_o0, 1'b1);
    check_b("fade_l0_inv", inv_o0, 1'b1);
    mode = 2'b01;
    frame();
    check_d("fade_l1", data_o0, 24'h5F5F5F);
    check_b("fade_l1_busy", busy_o0, 1'b1);
    frame();
    check_d("fade_l2", data_o0, 24'h7F7F7F);
    frame();
    check_d("fade_l3", data_o0, 24'h9F9F9F);
    check_b("fade_l3_busy", busy_o0, 1'b1);
    frame();
    check_d("fade_done", data_o0, 24'hBFBFBF);
    check_b("fade_done_busy", busy_o0, 1'b0);

    // Deferred request starts from mode_old = 10
    frame();
    check_d("req_l0", data_o0, 24'hBFBFBF);
    check_b("req_l0_busy", busy_o0, 1'b1);
    check_b("req_l0_inv", inv_o0, 1'b0);
    frame();
    check_d("req_l1", data_o0, 24'h9F9F9F);
    frame();
    check_d("req_l2", data_o0, 24'h7F7F7F);
    frame();
    check_d("req_l3", data_o0, 24'h5F5F5F);
    frame();
    check_d("req_done", data_o0, 24'h404040);
    check_b("req_done_busy", busy_o0, 1'b0);

    // Blanking and sync delay (same mode requested, so no fade)
    de = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    tick();
    check_b("sync_d1_hs", hs_o0, 1'b0);
    check_b("sync_d1_vs", vs_o0, 1'b0);
    check_b("sync_d1_de", de_o0, 1'b1);
    de = 1'b1;
    hs = 1'b0;
    vs = 1'b0;
    tick();
    check_b("sync_d2_hs", hs_o0, 1'b1);
    check_b("sync_d2_vs", vs_o0, 1'b1);
    check_b("sync_d2_de", de_o0, 1'b0);
    check_d("blank_data", data_o0, 24'h000000);
    tick();
    check_b("sync_d3_hs", hs_o0, 1'b0);
    check_d("unblank_data", data_o0, 24'h404040);
    repeat (2) tick();
    check_b("same_mode_busy", busy_o0, 1'b0);

    // Reset in the middle of a fade
    mode = 2'b10;
    frame();
    check_d("mid_l0", data_o0, 24'h404040);
    check_b("mid_l0_busy", busy_o0, 1'b1);
    frame();
    check_d("mid_l1", data_o0, 24'h5F5F5F);
    rst = 1'b1;
    #1;
    check_d("async_rst_data", data_o0, 24'h000000);
    check_b("async_rst_busy", busy_o0, 1'b0);
    check_b("async_rst_inv", inv_o0, 1'b0);
    mode = 2'b00;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_d("post_rst_data", data_o0, 24'h404040);
    check_b("post_rst_busy", busy_o0, 1'b0);

    // FADE_LOG2 = 0 instance: 00 -> 01 with bright blocks
    blk  = 1'b1;
    mode = 2'b01;
    repeat (2) tick();
    check_d("inst_pre", data_o1, 24'hBFBFBF);
    frame();
    check_d("inst_f0", data_o1, 24'hBFBFBF);
    check_b("inst_f0_busy", busy_o1, 1'b1);
    check_b("inst_f0_inv", inv_o1, 1'b0);
    check_d("slow_f0", data_o0, 24'hBFBFBF);
    frame();
    check_d("inst_f1", data_o1, 24'h404040);
    check_b("inst_f1_busy", busy_o1, 1'b0);
    check_d("slow_f1", data_o0, 24'h9F9F9F);
    check_b("slow_f1_busy", busy_o0, 1'b1);

    // Mode 11 with per-pixel source select
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mode = 2'b11;
    blk  = 1'b0;
    data = 24'h101010;
    alt  = 24'h202020;
    tick();
    repeat (5) frame();
    check_b("rev_busy", busy_o0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sel = ~i[0];
      tick();
      if (i > 0) begin
        check_d("srcsel_u0", data_o0, (i % 2 == 1) ? 24'hEFEFEF : 24'hDFDFDF);
        check_d("srcsel_u1", data_o1, (i % 2 == 1) ? 24'hEFEFEF : 24'hDFDFDF);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
